// File: rtl/gray_sequence_tx_if.sv
// Output handshake bundle: Gray code bus with valid/ready (plus parity when GRAY_PARITY_EN is defined).
// Latency: n/a (wires only). Backpressure: the sink holds out_ready low to stall the source.
interface gray_sequence_tx_if;
    logic out_valid;
    logic out_ready;
    logic g0;
    logic g1;
    logic g2;
    logic g3;
`ifdef GRAY_PARITY_EN
    logic parity;
`endif

    modport master (
        output out_valid,
        output g0,
        output g1,
        output g2,
        output g3,
`ifdef GRAY_PARITY_EN
        output parity,
`endif
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  g0,
        input  g1,
        input  g2,
        input  g3,
`ifdef GRAY_PARITY_EN
        input  parity,
`endif
        output out_ready
    );
endinterface

// File: rtl/gray_sequence_tx.sv
// Emits a run of 4-bit Gray codes from a loaded index up to LAST; optional parity output via GRAY_PARITY_EN.
// Latency: first code visible the cycle after start; one code per cycle while out_ready is high.
// Backpressure: code and out_valid hold while out_ready is low; stop aborts the run without done.
module gray_sequence_tx #(
    parameter int LAST = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       b0,
    input  logic                       b1,
    input  logic                       b2,
    input  logic                       b3,
    gray_sequence_tx_if.master         tx,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(LAST);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] g_q, g_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       xfer;

    function automatic logic [3:0] gray_enc(input logic [3:0] c);
        return c ^ (c >> 1);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xfer    = out_valid_q & tx.out_ready;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = {b0, b1, b2, b3};
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // stop wins over the final-index check, so a stopped run never reports done
                if (stop) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with cnt_q.
        out_valid_d = (state_d == S_RUN);
        busy_d      = (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
        g_d         = out_valid_d ? gray_enc(cnt_d) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            g_q         <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            g_q         <= g_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx.out_valid = out_valid_q;
    assign tx.g0        = g_q[3];
    assign tx.g1        = g_q[2];
    assign tx.g2        = g_q[1];
    assign tx.g3        = g_q[0];
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef GRAY_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^g_d;
        end
    end

    assign tx.parity = parity_q;
`endif

endmodule

// File: tb/tb_gray_sequence_tx.sv
// Bench for gray_sequence_tx: two instances (LAST=15 and LAST=1) share stimulus; a transfer-level
// scoreboard predicts each run's index list and a monitor checks every cycle at the falling edge.
module tb_gray_sequence_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, stop, b0, b1, b2, b3, out_ready;
    logic busy0, done0, busy1, done1;

    gray_sequence_tx_if if0 ();
    gray_sequence_tx_if if1 ();
    assign if0.out_ready = out_ready;
    assign if1.out_ready = out_ready;

    gray_sequence_tx #(.LAST(15)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .tx(if0.master), .busy(busy0), .done(done0)
    );

    gray_sequence_tx #(.LAST(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .tx(if1.master), .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;

    int expq [2][0:31];
    int rd [2];
    int wr [2];
    bit run_m [2];
    bit dpend [2];
    int last_idx [2];
    bit rst_prev;

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    // Expected run: every index from s upward (mod 16) until LAST inclusive.
    task automatic push_run(input int k, input int s);
        int i;
        rd[k] = 0;
        wr[k] = 0;
        i = s;
        forever begin
            expq[k][wr[k]] = i;
            wr[k]++;
            if (i == last_idx[k]) break;
            i = (i + 1) % 16;
        end
    endtask

    initial begin
        logic [3:0] gs [2];
        logic       ov [2];
        logic       bz [2];
        logic       dn [2];
        logic       pr [2];
        int         idx;
        last_idx[0] = 15;
        last_idx[1] = 1;
        rst_prev = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 0; wr[k] = 0; run_m[k] = 1'b0; dpend[k] = 1'b0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            gs[0] = {if0.g0, if0.g1, if0.g2, if0.g3};
            gs[1] = {if1.g0, if1.g1, if1.g2, if1.g3};
            ov[0] = if0.out_valid; ov[1] = if1.out_valid;
            bz[0] = busy0;         bz[1] = busy1;
            dn[0] = done0;         dn[1] = done1;
`ifdef GRAY_PARITY_EN
            pr[0] = if0.parity;    pr[1] = if1.parity;
`else
            pr[0] = 1'b0;          pr[1] = 1'b0;
`endif
            for (int k = 0; k < 2; k++) begin
                chk("out_valid", k, 8'(ov[k]), 8'(run_m[k]));
                chk("busy", k, 8'(bz[k]), 8'(run_m[k]));
                chk("done", k, 8'(dn[k]), 8'(dpend[k]));
                if (run_m[k]) begin
                    idx = expq[k][rd[k]];
                    chk("gray", k, 8'(gs[k]), 8'(idx ^ (idx >> 1)));
`ifdef GRAY_PARITY_EN
                    chk("parity", k, 8'(pr[k]), 8'(idx & 1));
`endif
                end else begin
                    if (rst_prev) chk("g_after_reset", k, 8'(gs[k]), 8'd0);
`ifdef GRAY_PARITY_EN
                    chk("parity_idle", k, 8'(pr[k]), 8'd0);
`endif
                end

                if (reset) begin
                    run_m[k] = 1'b0; dpend[k] = 1'b0; rd[k] = 0; wr[k] = 0;
                end else if (run_m[k]) begin
                    if (out_ready) rd[k]++;
                    if (stop) begin
                        run_m[k] = 1'b0;
                        rd[k] = wr[k];
                    end else if (rd[k] == wr[k]) begin
                        run_m[k] = 1'b0;
                        dpend[k] = 1'b1;
                    end
                end else if (dpend[k]) begin
                    dpend[k] = 1'b0;
                end else if (start) begin
                    push_run(k, int'({b0, b1, b2, b3}));
                    run_m[k] = 1'b1;
                end
            end
            rst_prev = reset;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_b(input int v);
        {b0, b1, b2, b3} = 4'(v);
    endtask

    task automatic pulse_start(input int v);
        set_b(v);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
        set_b(0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // full sequence from 0
        pulse_start(0);
        tick(20);

        // backpressure while index 5 is presented
        pulse_start(0);
        tick(5);
        out_ready = 1'b0;
        tick(3);
        out_ready = 1'b1;
        tick(15);

        // wrap from 14
        pulse_start(14);
        tick(20);

        // stop under backpressure at index 3, with an ignored start inside the run
        out_ready = 1'b0;
        pulse_start(0);
        out_ready = 1'b1;
        tick(3);
        out_ready = 1'b0;
        pulse_start(9);
        tick(2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(3);

        // reset mid-run, then an immediate restart
        out_ready = 1'b1;
        pulse_start(0);
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        pulse_start(3);
        tick(20);

        // randomized traffic
        repeat (3000) begin
            reset     = ($urandom % 400) == 0;
            start     = ($urandom % 4) == 0;
            stop      = ($urandom % 40) == 0;
            out_ready = ($urandom % 4) != 0;
            set_b(int'($urandom % 16));
            tick(1);
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
        tick(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
